// File: rtl/patch_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream. Two line buffers
// hold the previous rows; a 3x3 register window emits one patch per pixel.
module patch_buffer #(
    parameter int WIDTH = 32,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int SIZE  = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        din_valid,
    input  logic [WIDTH-1:0]            din,
    output logic                        buffer_valid,
    output logic [SIZE-1:0][WIDTH-1:0]  patch,
    output logic                        frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [WIDTH-1:0]         r_lb0 [IMG_W];
    logic [WIDTH-1:0]         r_lb1 [IMG_W];
    logic [2:0][2:0][WIDTH-1:0] r_win;
    logic                     r_valid;
    logic                     r_fd;

    logic                     w_acc;
    logic                     w_last_col;
    logic                     w_last_row;
    logic [WIDTH-1:0]         w_top;
    logic [WIDTH-1:0]         w_mid;

    assign w_acc      = din_valid & ~clear;
    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));
    assign w_top      = r_lb1[r_col];
    assign w_mid      = r_lb0[r_col];

    // Line buffers are never reset: every entry is rewritten before it can
    // reach a window that is flagged valid.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_fd    <= 1'b0;
            r_win   <= '0;
        end else if (clear) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_fd    <= 1'b0;
        end else if (din_valid) begin
            r_valid <= (r_row >= RW'(2)) && (r_col >= CW'(2));
            r_fd    <= w_last_row && w_last_col;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_top;
            r_win[1][2] <= w_mid;
            r_win[2][2] <= din;
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else begin
            r_valid <= 1'b0;
            r_fd    <= 1'b0;
        end
    end

    // Packed [row][col] flattens to row-major order: patch[3*row+col].
    assign patch        = r_win;
    assign buffer_valid = r_valid;
    assign frame_done   = r_fd;
endmodule
